fread_responder: RTL and testbench
==================================

# fread_responder

Serving end of the "fread" request/response stream. It holds a byte image loaded from a byte stream (UART RX) in block RAM, accepts offset requests, and streams a fixed-length block of bytes starting at that offset. It lets a loader block be exercised on-chip without the ESP.

## Interface
Parameters:
- MEM_DEPTH, 12288 — image size in bytes (0x3000).
- BLOCK_LEN, 2048 — bytes returned per request (0x800).
- PAD, 8'hFF — byte returned for any address ≥ MEM_DEPTH (past end of file).

Ports:
- clk  in  1  — single clock; all logic is on its rising edge.
- rst_n  in  1  — reset, asynchronous and active-low.
- load_data  in  8  — image byte.
- load_valid  in  1  — load_data is valid.
- load_ready  out  1  — high only in LOAD; a byte is written when load_valid & load_ready.
- loaded  out  1  — image complete; sticky until reset.
- req_valid  in  1  — request present.
- req_ready  out  1  — high only in IDLE.
- req_offset  in  32  — start byte address; sampled on accept.
- resp_data  out  8  — response byte.
- resp_valid  out  1  — resp_data is valid.
- resp_ready  in  1  — consumer accepts; a transfer occurs on resp_valid & resp_ready.
- resp_last  out  1  — marks byte BLOCK_LEN-1 of the block.
- busy  out  1  — high in STREAM.

## Operation
- States are LOAD → IDLE ⇄ STREAM. Reset enters LOAD.
- LOAD:
  - Each accepted load byte is written to mem[wr_addr]; wr_addr increments.
  - After the write at wr_addr = MEM_DEPTH-1, go to IDLE and set loaded.
  - req_ready = 0 throughout.
- IDLE:
  - On req_valid & req_ready, latch base = req_offset, clear rd_cnt and tx_cnt, go to STREAM.
- STREAM:
  - Issue reads for byte i = rd_cnt. The address is the 33-bit sum {1'b0, base} + i.
  - If the sum is ≥ MEM_DEPTH, including the 32-bit carry case, the byte is PAD and the RAM is not read.
  - The RAM has 1-cycle read latency. Read data and PAD bytes enter a 2-entry output skid FIFO that drives resp_*.
  - A read issues only when FIFO occupancy plus in-flight reads is < 2, and only while rd_cnt < BLOCK_LEN.
  - tx_cnt counts transfers. resp_last = (tx_cnt == BLOCK_LEN-1) & resp_valid.
  - On the transfer of the last byte, go to IDLE.
- Handshake: resp_data and resp_last stay stable while resp_valid & ~resp_ready. resp_valid is never withdrawn without a transfer.
- Memory contents are not cleared by reset. After reset, loaded = 0 and a full reload is required.
- Counters: rd_cnt and tx_cnt are $clog2(BLOCK_LEN+1) bits wide; wr_addr is $clog2(MEM_DEPTH) bits wide.

## Timing
- Reset values:
  - load_ready = 1 (LOAD).
  - loaded = 0, req_ready = 0, resp_valid = 0, resp_data = 0, resp_last = 0, busy = 0.
  - FIFO empty, all counters 0.
- Request accepted on cycle N: busy = 1 at N+1, first read issued at N+1, resp_valid = 1 at N+2.
- With resp_ready held high: one byte per cycle. The last transfer is at N+1+BLOCK_LEN; req_ready = 1 on the following cycle.
- Stall: resp_ready low for k cycles adds exactly k cycles. No bytes are lost or duplicated.
- Load: the byte accepted on cycle M is readable from M+1. The final load write on cycle M gives loaded = 1 and req_ready = 1 at M+1.
- req_valid asserted during LOAD or STREAM is ignored and left pending (req_ready = 0). It is accepted on the first IDLE cycle.
- rst_n asserted mid-stream: all outputs take reset values immediately (asynchronously). Any in-flight read is discarded.

## Structure
- Shared package fread_pkg holds:
  - state enum {LOAD, IDLE, STREAM};
  - constants FREAD_BLOCK_LEN = 2048 and FREAD_PAD = 8'hFF, shared with the loader side.
- One natural sub-module: fread_skid2, the 2-entry valid/ready output FIFO with occupancy output.
- The RAM is inferred inline as a synchronous-read array.

## Test plan
- Load bytes i & 8'hFF for i = 0..MEM_DEPTH-1 with random load_valid gaps → loaded rises 1 cycle after the last byte; load_ready = 0 afterwards.
- Request offset 0x000 with resp_ready = 1:
  - 2048 bytes 0x00..0xFF repeating, back to back;
  - first resp_valid 2 cycles after accept;
  - resp_last only on byte 2047.
- Request offset 0x2C00 → bytes 0x00..0xFF for the 1024 in-range addresses 0x2C00..0x2FFF, then 1024 bytes of 0xFF, with resp_last on byte 2047.
- Request offset 0xFFFFFC00 → first 1024 bytes 0xFF. Remaining 1024 bytes are also 0xFF: the address carries past 2^32 and is treated as past end.
- Random resp_ready with 30% duty on a request at offset 0x0800 → byte sequence identical to the resp_ready = 1 case; data stable during stalls; exactly 2048 transfers.
- rst_n pulsed low mid-stream at byte 500:
  - resp_valid = 0 and busy = 0 immediately;
  - after release, load_ready = 1, loaded = 0, req_ready = 0 until a reload completes.

Source files
------------

// File: rtl/fread_pkg.sv
// fread_pkg: state encoding and constants shared by the fread responder and loader side
package fread_pkg;
  typedef enum logic [1:0] {LOAD, IDLE, STREAM} state_t;
  localparam int FREAD_BLOCK_LEN = 2048;
  localparam logic [7:0] FREAD_PAD = 8'hFF;
endpackage

// File: rtl/fread_skid2.sv
// fread_skid2: two-entry valid/ready output FIFO that passes data straight through when empty
module fread_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   occ
);
  logic [W-1:0] d0, d1, q0, q1;
  logic take;
  // queue view {d0, d1, in} with the head taken when the consumer accepts
  always_comb begin
    q0 = occ != 2'd0 ? d0 : in_data;
    q1 = occ == 2'd2 ? d1 : in_data;
    out_valid = occ != 2'd0 || in_valid;
    out_data = (occ == 2'd0 && in_valid) ? in_data : d0;
    take = out_valid && out_ready;
  end
  // storage: shift the queue by one when the head is taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d0 <= '0;
      d1 <= '0;
      occ <= 2'd0;
    end else begin
      occ <= occ + {1'b0, in_valid} - {1'b0, take};
      if (take || in_valid) begin
        d0 <= take ? q1 : q0;
        d1 <= take ? in_data : q1;
      end
    end
endmodule

// File: rtl/fread_responder.sv
// fread_responder: serves fixed-length byte blocks from a UART-loaded image held in block RAM
module fread_responder
  import fread_pkg::*;
#(
  parameter int         MEM_DEPTH = 12288,
  parameter int         BLOCK_LEN = FREAD_BLOCK_LEN,
  parameter logic [7:0] PAD       = FREAD_PAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        loaded,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_offset,
  output logic [7:0]  resp_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_last,
  output logic        busy
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(BLOCK_LEN + 1);
  localparam logic [AW-1:0] WR_LAST  = AW'(MEM_DEPTH - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(BLOCK_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_LEN - 1);
  localparam logic [32:0]   ADDR_END = 33'(MEM_DEPTH);

  state_t state, state_nx;
  logic [AW-1:0] wr_addr;
  logic [31:0] base;
  logic [CW-1:0] rd_cnt, tx_cnt;
  logic [32:0] rd_addr;
  logic load_fire, load_end, req_fire, xfer, issue, rd_pad, inf_v, inf_pad;
  logic [7:0] mem [MEM_DEPTH];
  logic [7:0] ram_q;
  logic [1:0] occ;

  fread_skid2 #(.W(8)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (inf_pad ? PAD : ram_q),
    .in_valid  (inf_v),
    .out_data  (resp_data),
    .out_valid (resp_valid),
    .out_ready (resp_ready),
    .occ       (occ)
  );

  // handshakes, read issue gating and next state
  always_comb begin
    load_ready = state == LOAD;
    req_ready = state == IDLE;
    busy = state == STREAM;
    load_fire = load_ready && load_valid;
    load_end = load_fire && wr_addr == WR_LAST;
    req_fire = req_ready && req_valid;
    xfer = resp_valid && resp_ready;
    rd_addr = {1'b0, base} + 33'(rd_cnt);
    rd_pad = rd_addr >= ADDR_END;
    issue = busy && rd_cnt < CNT_END && (3'(occ) + 3'(inf_v)) < 3'd2;
    resp_last = resp_valid && tx_cnt == CNT_LAST;
    state_nx = load_end ? IDLE : req_fire ? STREAM : (xfer && resp_last) ? IDLE : state;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD;
    else state <= state_nx;

  // load address, stream counters and the one-deep read pipeline tag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_addr <= '0;
      loaded <= 1'b0;
      base <= '0;
      rd_cnt <= '0;
      tx_cnt <= '0;
      inf_v <= 1'b0;
      inf_pad <= 1'b0;
    end else begin
      if (load_fire) wr_addr <= load_end ? '0 : wr_addr + 1'b1;
      if (load_end) loaded <= 1'b1;
      if (req_fire) begin
        base <= req_offset;
        rd_cnt <= '0;
        tx_cnt <= '0;
      end else begin
        if (issue) rd_cnt <= rd_cnt + 1'b1;
        if (xfer) tx_cnt <= tx_cnt + 1'b1;
      end
      inf_v <= issue;
      inf_pad <= rd_pad;
    end

  // image RAM: written during load, synchronous read skipped for past-end addresses
  always_ff @(posedge clk) begin
    if (load_fire) mem[wr_addr] <= load_data;
    if (issue && !rd_pad) ram_q <= mem[rd_addr[AW-1:0]];
  end
endmodule

// File: tb/tb_fread_responder.sv
// tb_fread_responder: randomized load/request traffic checked against a byte-image model
module tb_fread_responder;
  localparam int MD = 12288;
  localparam int BL = 2048;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] load_data;
  logic load_valid, load_ready, loaded;
  logic req_valid, req_ready;
  logic [31:0] req_offset;
  logic [7:0] resp_data;
  logic resp_valid, resp_ready, resp_last, busy;

  fread_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .loaded     (loaded),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_offset (req_offset),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_last  (resp_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] img [MD];
  logic [7:0] exp_b [BL];
  logic [7:0] got [BL];
  int req_id = 0, seen_id = 0, idx = BL, stalls = 0, first_cyc = -1, last_cyc = -1;
  logic hold = 1'b0, h_last = 1'b0;
  logic [7:0] h_data = 8'h00;

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, g, e, cyc);
    end
  endtask

  // scoreboard: every output cycle is checked against the expected block
  always @(negedge clk) begin
    if (!rst_n) begin
      idx = BL;
      hold = 1'b0;
    end else begin
      if (req_id != seen_id) begin
        seen_id = req_id;
        idx = 0;
        stalls = 0;
        first_cyc = -1;
        last_cyc = -1;
      end
      if (hold) begin
        chk("hold_valid", resp_valid, 1);
        chk("hold_data", resp_data, h_data);
        chk("hold_last", resp_last, h_last);
      end
      if (resp_valid) begin
        if (idx >= BL) chk("spurious_valid", resp_valid, 0);
        else begin
          if (first_cyc < 0) first_cyc = cyc;
          chk("data", resp_data, exp_b[idx]);
          chk("last", resp_last, idx == BL - 1);
          if (resp_ready) begin
            got[idx] = resp_data;
            if (idx == BL - 1) last_cyc = cyc;
            idx++;
          end else stalls++;
        end
      end else chk("last_idle", resp_last, 0);
      hold = resp_valid && !resp_ready;
      h_data = resp_data;
      h_last = resp_last;
    end
  end

  task automatic load_image(input bit ramp);
    int bad_lr, bad_rr, g;
    bad_lr = 0;
    bad_rr = 0;
    for (int i = 0; i < MD; i++) begin
      img[i] = ramp ? 8'(i) : 8'($urandom);
      load_valid = 1'b0;
      g = 0;
      while ($urandom_range(0, 99) < 30 && g < 3) begin
        if (req_ready) bad_rr++;
        @(posedge clk); #1;
        g++;
      end
      load_data = img[i];
      load_valid = 1'b1;
      if (!load_ready) bad_lr++;
      if (req_ready) bad_rr++;
      if (i == MD - 1) chk("loaded_before_last", loaded, 0);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    chk("load_ready_during_load", bad_lr, 0);
    chk("req_ready_during_load", bad_rr, 0);
    chk("loaded_after_last", loaded, 1);
    chk("req_ready_after_load", req_ready, 1);
    chk("load_ready_after_load", load_ready, 0);
  endtask

  task automatic do_req(input logic [31:0] off, input int duty, input int stop_at);
    int t, n;
    longint a;
    req_offset = off;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("req_ready_seen", req_ready, 1);
    n = cyc;
    for (int i = 0; i < BL; i++) begin
      a = longint'(off) + longint'(i);
      exp_b[i] = (a < MD) ? img[a] : 8'hFF;
    end
    req_id++;
    resp_ready = $urandom_range(0, 99) < duty;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("req_ready_after_accept", req_ready, 0);
    t = 0;
    while (idx < stop_at && t < 20000) begin
      resp_ready = $urandom_range(0, 99) < duty;
      @(posedge clk); #1;
      t++;
    end
    if (stop_at >= BL) begin
      chk("stream_done", idx, BL);
      chk("first_valid_cyc", first_cyc, n + 2);
      chk("last_xfer_cyc", last_cyc, n + 1 + BL + stalls);
      chk("req_ready_end", req_ready, 1);
      chk("busy_end", busy, 0);
    end else chk("reached_stop", idx, stop_at);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time 2000000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    load_valid = 1'b0;
    load_data = 8'h00;
    req_valid = 1'b0;
    req_offset = 32'h0;
    resp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_loaded", loaded, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_last", resp_last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    load_image(1'b1);
    do_req(32'h0, 100, BL);
    chk("pin_off0_b0", got[0], 8'h00);
    chk("pin_off0_b255", got[255], 8'hFF);
    chk("pin_off0_b256", got[256], 8'h00);
    chk("pin_off0_b2047", got[2047], 8'hFF);
    do_req(32'h2C00, 100, BL);
    chk("pin_2c00_b512", got[512], 8'h00);
    chk("pin_2c00_b1000", got[1000], 8'hE8);
    chk("pin_2c00_b1024", got[1024], 8'hFF);
    do_req(32'hFFFFFC00, 100, BL);
    chk("pin_wrap_b0", got[0], 8'hFF);
    chk("pin_wrap_b1500", got[1500], 8'hFF);
    do_req(32'h0800, 30, BL);
    chk("pin_800_b5", got[5], 8'h05);
    chk("pin_800_b300", got[300], 8'h2C);
    for (int r = 0; r < 2; r++) do_req(32'($urandom_range(0, 16383)), 50, BL);
    do_req(32'h1000, 100, 500);
    chk("valid_before_rst", resp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_resp_last", resp_last, 0);
    chk("midrst_resp_data", resp_data, 0);
    chk("midrst_load_ready", load_ready, 1);
    chk("midrst_loaded", loaded, 0);
    chk("midrst_req_ready", req_ready, 0);
    @(posedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    req_offset = 32'h2FF0;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_load_ready", load_ready, 1);
      chk("post_rst_loaded", loaded, 0);
      chk("post_rst_req_ready", req_ready, 0);
    end
    load_image(1'b0);
    do_req(32'h2FF0, 100, BL);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
